// File: rtl/irq_ctrl_n.sv
// Vectored interrupt controller with rotating priority, per-line edge/level
// triggering, masking, in-service tracking, EOI commands and a polled acknowledge.
module irq_ctrl_n #(
   parameter int         NUM_IRQ  = 8,
   parameter logic [7:0] SPUR_VEC = 8'hFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         io_address,
   input  logic               io_read,
   output logic [15:0]        io_readdata,
   input  logic               io_write,
   input  logic [15:0]        io_writedata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               int_req,
   input  logic               int_ack,
   output logic               int_vec_valid,
   output logic [7:0]         int_vector
);

   localparam logic [4:0] N5 = 5'(NUM_IRQ);

   logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
   logic [NUM_IRQ-1:0] trig_q, trig_d, prev_q, prev_d;
   logic [10:0]        ctrl_q, ctrl_d;
   logic [3:0]         low_pri_q, low_pri_d;
   logic               int_req_q, int_req_d, vec_valid_q, vec_valid_d;
   logic [7:0]         vector_q, vector_d;

   // Rank 0 is the highest priority line, i.e. (lp+1) mod NUM_IRQ.
   function automatic logic [3:0] rank_of(input logic [3:0] i, input logic [3:0] lp);
      logic [4:0] t;
      t = {1'b0, i} + N5 - 5'd1 - {1'b0, lp};
      if (t >= N5) t = t - N5;
      return t[3:0];
   endfunction

   // Returns {found, index, rank} of the highest priority set bit.
   function automatic logic [8:0] pick(input logic [NUM_IRQ-1:0] v, input logic [3:0] lp);
      logic       found;
      logic [3:0] idx, best, r;
      found = 1'b0;
      idx   = '0;
      best  = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         r = rank_of(4'(i), lp);
         if (v[i] && (!found || r < best)) begin
            found = 1'b1;
            idx   = 4'(i);
            best  = r;
         end
      end
      return {found, idx, best};
   endfunction

   function automatic logic [15:0] pad16(input logic [NUM_IRQ-1:0] v);
      logic [15:0] r;
      r = '0;
      r[NUM_IRQ-1:0] = v;
      return r;
   endfunction

   logic [NUM_IRQ-1:0] cand, rise, ack_mask, trig_chg;
   logic               win_found, isr_found, eligible;
   logic [3:0]         win_idx, win_rank, isr_idx, isr_rank;
   logic               wr_cmd, cmd_idx_ok, poll_rd, ack_any, ack_take;
   logic               eoi_do, cmd_clr, trig_wr;
   logic [3:0]         eoi_idx;
   logic [1:0]         cmd;
   logic               unused_wd;

   assign cand = irr_q & ~imr_q & ~isr_q;
   assign rise = irq_in & ~prev_q;
   assign {win_found, win_idx, win_rank} = pick(cand, low_pri_q);
   assign {isr_found, isr_idx, isr_rank} = pick(isr_q, low_pri_q);
   assign eligible = win_found && (ctrl_q[10] || !isr_found || win_rank < isr_rank);

   assign wr_cmd     = io_write && io_address == 3'd0;
   assign cmd        = io_writedata[15:14];
   assign cmd_idx_ok = {1'b0, io_writedata[3:0]} < N5;
   assign poll_rd    = io_read && io_address == 3'd5;
   assign ack_any    = int_ack || poll_rd;
   assign ack_take   = ack_any && eligible;
   assign cmd_clr    = wr_cmd && cmd == 2'd3;
   assign trig_wr    = io_write && io_address == 3'd3;
   assign trig_chg   = trig_wr ? (io_writedata[NUM_IRQ-1:0] ^ trig_q) : '0;
   assign unused_wd  = ^io_writedata[13:11];

   always_comb begin
      eoi_do  = 1'b0;
      eoi_idx = '0;
      if (wr_cmd && cmd == 2'd0 && isr_found) begin
         eoi_do  = 1'b1;
         eoi_idx = isr_idx;
      end else if (wr_cmd && cmd == 2'd1 && cmd_idx_ok) begin
         eoi_do  = 1'b1;
         eoi_idx = io_writedata[3:0];
      end
   end

   always_comb begin
      irr_d     = irr_q;
      isr_d     = isr_q;
      ack_mask  = '0;
      imr_d     = imr_q;
      trig_d    = trig_q;
      ctrl_d    = ctrl_q;
      low_pri_d = low_pri_q;
      prev_d    = irq_in;
      for (int i = 0; i < NUM_IRQ; i++) begin
         ack_mask[i] = ack_take && win_idx == 4'(i);
         // A fresh edge wins over the acknowledge clear on the same line.
         if (trig_q[i]) irr_d[i] = irq_in[i];
         else if (ack_mask[i]) irr_d[i] = 1'b0;
         if (cmd_clr) irr_d[i] = 1'b0;
         if (!trig_q[i] && rise[i]) irr_d[i] = 1'b1;
         if (trig_chg[i]) irr_d[i] = 1'b0;
         // EOI clear is applied before the acknowledge set.
         if (eoi_do && eoi_idx == 4'(i)) isr_d[i] = 1'b0;
         if (ack_mask[i] && !ctrl_q[8]) isr_d[i] = 1'b1;
      end
      if (wr_cmd && cmd == 2'd0 && isr_found && ctrl_q[9]) low_pri_d = isr_idx;
      if (wr_cmd && cmd == 2'd2 && cmd_idx_ok) low_pri_d = io_writedata[3:0];
      if (ack_take && ctrl_q[8] && ctrl_q[9]) low_pri_d = win_idx;
      if (io_write && io_address == 3'd2) imr_d = io_writedata[NUM_IRQ-1:0];
      if (trig_wr) trig_d = io_writedata[NUM_IRQ-1:0];
      if (io_write && io_address == 3'd4) ctrl_d = io_writedata[10:0];
   end

   always_comb begin
      int_req_d   = ack_any ? 1'b0 : eligible;
      vec_valid_d = int_ack;
      vector_d    = vector_q;
      if (int_ack) vector_d = eligible ? ctrl_q[7:0] + {4'b0, win_idx} : SPUR_VEC;
   end

   always_comb begin
      io_readdata = '0;
      case (io_address)
         3'd0:    io_readdata = pad16(irr_q);
         3'd1:    io_readdata = pad16(isr_q);
         3'd2:    io_readdata = pad16(imr_q);
         3'd3:    io_readdata = pad16(trig_q);
         3'd4:    io_readdata = {5'b0, ctrl_q};
         3'd5:    io_readdata = {eligible, 11'b0, win_idx};
         default: io_readdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irr_q       <= '0;
         isr_q       <= '0;
         imr_q       <= '1;
         trig_q      <= '0;
         prev_q      <= '0;
         ctrl_q      <= '0;
         low_pri_q   <= 4'(NUM_IRQ - 1);
         int_req_q   <= 1'b0;
         vec_valid_q <= 1'b0;
         vector_q    <= '0;
      end else begin
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         imr_q       <= imr_d;
         trig_q      <= trig_d;
         prev_q      <= prev_d;
         ctrl_q      <= ctrl_d;
         low_pri_q   <= low_pri_d;
         int_req_q   <= int_req_d;
         vec_valid_q <= vec_valid_d;
         vector_q    <= vector_d;
      end
   end

   assign int_req       = int_req_q;
   assign int_vec_valid = vec_valid_q;
   assign int_vector    = vector_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Directed checks of irq_ctrl_n with an 8-line and a 5-line instance sharing
// the bus, acknowledge and the low interrupt lines.
module tb_irq_ctrl_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  io_address = '0;
   logic        io_read = 1'b0, io_write = 1'b0, int_ack = 1'b0;
   logic [15:0] io_writedata = '0;
   logic [7:0]  irq = '0;
   logic [15:0] rd8, rd5;
   logic        req8, req5, vv8, vv5;
   logic [7:0]  vec8, vec5;
   logic        sel5 = 1'b0;
   int          total = 0, bad = 0;

   always #10 clk = ~clk;

   irq_ctrl_n #(.NUM_IRQ(8)) dut8 (
      .clk(clk), .rst(rst), .io_address(io_address), .io_read(io_read),
      .io_readdata(rd8), .io_write(io_write), .io_writedata(io_writedata),
      .irq_in(irq), .int_req(req8), .int_ack(int_ack),
      .int_vec_valid(vv8), .int_vector(vec8));

   irq_ctrl_n #(.NUM_IRQ(5)) dut5 (
      .clk(clk), .rst(rst), .io_address(io_address), .io_read(io_read),
      .io_readdata(rd5), .io_write(io_write), .io_writedata(io_writedata),
      .irq_in(irq[4:0]), .int_req(req5), .int_ack(int_ack),
      .int_vec_valid(vv5), .int_vector(vec5));

   function automatic logic [15:0] cur_req();
      return {15'b0, sel5 ? req5 : req8};
   endfunction
   function automatic logic [15:0] cur_vv();
      return {15'b0, sel5 ? vv5 : vv8};
   endfunction
   function automatic logic [15:0] cur_vec();
      return {8'b0, sel5 ? vec5 : vec8};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; io_write = 1'b0; io_read = 1'b0; int_ack = 1'b0; irq = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] v);
      io_address = a; io_writedata = v; io_write = 1'b1;
      tick();
      io_write = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      io_address = a;
      #1;
      chk(tag, sel5 ? rd5 : rd8, exp);
   endtask

   task automatic ack_chk(input string tag, input logic [7:0] exp_vec);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk({tag, " vv"}, cur_vv(), 16'd1);
      chk({tag, " vec"}, cur_vec(), {8'b0, exp_vec});
   endtask

   initial begin
      // Reset state and single edge interrupt on line 3
      do_reset();
      rdchk("rst imr", 3'd2, 16'h00FF);
      rdchk("rst irr", 3'd0, 16'h0000);
      rdchk("rst isr", 3'd1, 16'h0000);
      chk("rst req", cur_req(), 16'd0);
      chk("rst vv", cur_vv(), 16'd0);
      chk("rst vec", cur_vec(), 16'd0);
      tick();
      rdchk("rst trig", 3'd3, 16'h0000);
      rdchk("rst ctrl", 3'd4, 16'h0000);
      wr(3'd2, 16'h0000);
      wr(3'd4, 16'h0040);
      irq[3] = 1'b1;
      tick();
      chk("t1 req 1cyc", cur_req(), 16'd0);
      tick();
      chk("t1 req 2cyc", cur_req(), 16'd1);
      ack_chk("t1", 8'h43);
      rdchk("t1 isr", 3'd1, 16'h0008);
      rdchk("t1 irr", 3'd0, 16'h0000);
      chk("t1 req clr", cur_req(), 16'd0);
      tick();
      chk("t1 vv pulse", cur_vv(), 16'd0);

      // Simultaneous lines 2 and 5, then non-specific EOI
      do_reset();
      wr(3'd2, 16'h0000);
      wr(3'd4, 16'h0040);
      irq = 8'h24;
      tick(); tick();
      chk("t2 req", cur_req(), 16'd1);
      ack_chk("t2a", 8'h42);
      tick(); tick();
      chk("t2 req blocked", cur_req(), 16'd0);
      wr(3'd0, 16'h0000);
      tick();
      chk("t2 req eoi", cur_req(), 16'd1);
      ack_chk("t2b", 8'h45);
      rdchk("t2 isr", 3'd1, 16'h0020);

      // In-service line 1 blocks line 4 until special mask mode
      do_reset();
      wr(3'd2, 16'h0000);
      wr(3'd4, 16'h0040);
      irq = 8'h02;
      tick(); tick();
      ack_chk("t3a", 8'h41);
      irq[4] = 1'b1;
      tick(); tick(); tick();
      chk("t3 req nested", cur_req(), 16'd0);
      wr(3'd4, 16'h0440);
      tick();
      chk("t3 req smm", cur_req(), 16'd1);
      ack_chk("t3b", 8'h44);
      rdchk("t3 isr", 3'd1, 16'h0012);

      // Level line dropped before acknowledge gives a spurious vector
      do_reset();
      wr(3'd2, 16'h0000);
      wr(3'd3, 16'h0001);
      wr(3'd4, 16'h0040);
      irq[0] = 1'b1;
      tick(); tick();
      chk("t4 req", cur_req(), 16'd1);
      irq[0] = 1'b0;
      tick();
      ack_chk("t4", 8'hFF);
      rdchk("t4 isr", 3'd1, 16'h0000);
      rdchk("t4 irr", 3'd0, 16'h0000);
      rdchk("t4 trig", 3'd3, 16'h0001);

      // Five lines, rotate-on-EOI moves lowest priority to the serviced line
      sel5 = 1'b1;
      do_reset();
      rdchk("t5 imr rst", 3'd2, 16'h001F);
      wr(3'd2, 16'h0000);
      wr(3'd4, 16'h0240);
      wr(3'd0, 16'h8001);
      irq = 8'h10;
      tick(); tick();
      chk("t5 req", cur_req(), 16'd1);
      ack_chk("t5a", 8'h44);
      wr(3'd0, 16'h0000);
      irq = 8'h0B;
      tick(); tick();
      chk("t5 req2", cur_req(), 16'd1);
      ack_chk("t5b", 8'h40);
      wr(3'd0, 16'h0000);
      tick();
      ack_chk("t5c", 8'h41);
      wr(3'd0, 16'h0000);
      io_address = 3'd5;
      io_read = 1'b1;
      #1;
      chk("t5 poll", rd5, 16'h8003);
      tick();
      io_read = 1'b0;
      chk("t5 poll vv", cur_vv(), 16'd0);
      rdchk("t5 poll isr", 3'd1, 16'h0008);

      // Reset between acknowledge and vector pulse
      do_reset();
      wr(3'd2, 16'h0000);
      irq = 8'h04;
      tick(); tick();
      chk("t6 req", cur_req(), 16'd1);
      int_ack = 1'b1;
      #2;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      int_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t6 no vv", cur_vv(), 16'd0);
         tick();
      end
      rdchk("t6 isr", 3'd1, 16'h0000);
      rdchk("t6 imr", 3'd2, 16'h001F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/irq_ctrl_n.md
IRQ_CTRL_N -- requirements
Module: irq_ctrl_n

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt lines; legal range 2..16.
REQ-002 SHALL have parameter SPUR_VEC, default 8'hFF, vector returned for a spurious acknowledge.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have io_address  input  3  register select.
REQ-006 SHALL have io_read  input  1  one-cycle read strobe.
REQ-007 SHALL have io_readdata  output  16  combinational read data; bits at or above NUM_IRQ read 0.
REQ-008 SHALL have io_write  input  1  one-cycle write strobe.
REQ-009 SHALL have io_writedata  input  16  write data.
REQ-010 SHALL have irq_in  input  NUM_IRQ  raw interrupt lines; bit 0 is line 0.
REQ-011 SHALL have int_req  output  1  interrupt request to the CPU.
REQ-012 SHALL have int_ack  input  1  one-cycle acknowledge pulse from the CPU.
REQ-013 SHALL have int_vec_valid  output  1  one-cycle pulse, asserted the cycle after int_ack.
REQ-014 SHALL have int_vector  output  8  vector, valid while int_vec_valid is high.

Function
REQ-015 Register map SHALL be:
- 0: read IRR; write command.
- 1: read ISR.
- 2: IMR, R/W, 1 = masked.
- 3: TRIG, R/W, 1 = level-triggered, 0 = rising-edge-triggered.
- 4: CTRL, R/W:
  - [7:0] vector base.
  - [8] auto-EOI.
  - [9] rotate-on-EOI.
  - [10] special mask mode.
- 5: POLL, read only.
- 6, 7: read 0, writes ignored.
REQ-016 Edge detection SHALL compare irq_in against a one-cycle registered copy.
- Edge line: IRR bit sets on a rising edge and stays set until acknowledged.
- Level line: IRR bit follows irq_in.
REQ-017 Candidate set SHALL be IRR & ~IMR & ~ISR.
REQ-018 Priority SHALL rotate using a register low_pri; the highest-priority line is (low_pri+1) mod NUM_IRQ, decreasing cyclically from there.
REQ-019 All priority index arithmetic SHALL wrap modulo NUM_IRQ, including non-power-of-two NUM_IRQ.
REQ-020 int_req SHALL be registered: set the cycle after a candidate exists whose priority beats the highest in-service line (or any candidate when special mask mode = 1).
REQ-021 int_req SHALL clear the cycle after int_ack.
REQ-022 On int_ack, the winning candidate SHALL be selected from the current cycle's state. The following cycle:
- int_vector = base + index (8-bit, wrapping);
- that line's IRR bit clears (edge lines only);
- its ISR bit sets, unless auto-EOI is enabled.
REQ-023 If int_ack arrives with no eligible candidate, the block SHALL output int_vector = SPUR_VEC and change no IRR, ISR or low_pri state.
REQ-024 With auto-EOI and rotate-on-EOI both set, a non-spurious acknowledge SHALL set low_pri to the acknowledged index.
REQ-025 Commands written to address 0, selected by writedata[15:14], SHALL be:
- 00: non-specific EOI; clears the highest-priority ISR bit. If rotate-on-EOI is set, low_pri becomes that index.
- 01: specific EOI; clears ISR[writedata[3:0]].
- 10: low_pri = writedata[3:0].
- 11: clear all IRR bits.
REQ-026 Commands 01 and 10 with writedata[3:0] >= NUM_IRQ SHALL be ignored; a non-specific EOI with ISR = 0 SHALL have no effect.
REQ-027 A POLL read SHALL return {valid, 11'b0, index[3:0]} and act as an acknowledge when valid = 1, but SHALL NOT produce int_vec_valid.
REQ-028 Same-cycle ordering SHALL be:
- an EOI and an acknowledge in the same cycle both take effect, with the EOI clear applied before the acknowledge set;
- a register write and an acknowledge in the same cycle: the acknowledge uses pre-write IMR/CTRL;
- a new edge on the same line as an acknowledge leaves IRR set.
REQ-029 Writing TRIG SHALL clear IRR bits whose mode changes.
REQ-030 Bits at or above NUM_IRQ in IMR, TRIG and commands SHALL be ignored.

Reset
REQ-031 While rst is high, the block SHALL hold:
- IMR all ones;
- IRR, ISR, TRIG, CTRL and the edge-history register 0;
- low_pri = NUM_IRQ-1;
- int_req, int_vec_valid and int_vector 0.
REQ-032 Reset asserted mid-handshake SHALL abort the handshake; after release no int_vec_valid pulse is produced for a pre-reset int_ack.

Verification
REQ-033 The bench SHALL cover: NUM_IRQ=8, IMR=0, CTRL base=8'h40, edge on irq_in[3] -> int_req=1 two cycles later; int_ack -> next cycle int_vec_valid=1, int_vector=8'h43, ISR=16'h0008, IRR=0.
REQ-034 The bench SHALL cover: lines 2 and 5 rise in the same cycle with low_pri=7 -> vector base+2 first; non-specific EOI -> int_req again; vector base+5.
REQ-035 The bench SHALL cover: ISR bit 1 active, line 4 raised -> no int_req; special mask mode=1 -> int_req=1.
REQ-036 The bench SHALL cover: level line 0 raised, int_req high, line dropped before int_ack -> int_vector=8'hFF and ISR unchanged.
REQ-037 The bench SHALL cover: NUM_IRQ=5, rotate-on-EOI=1, acknowledge plus EOI on line 4 -> low_pri=4; next priority order 0,1,2,3,4.
REQ-038 The bench SHALL cover: rst pulsed between int_ack and int_vec_valid -> no pulse; IMR reads 16'h001F for NUM_IRQ=5.
